// File: rtl/lp_smpl_queue_pkg.sv
// Shared defaults and types for the LP sample queue: tap count, buffer depth,
// pointer width and the readout FSM state encoding.
package eq_pkg;

    localparam int unsigned DEF_TAPS  = 1021;
    localparam int unsigned DEF_DEPTH = 1024;
    localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/lp_smpl_queue_if.sv
// Sample-in / window-out bundle between the sample producer and the queue.
// The producer side is the master; the queue itself is the slave.
interface lp_smpl_queue_if;

    logic signed [15:0] lft_smpl;
    logic signed [15:0] rght_smpl;
    logic               wrt_smpl;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               sequencing;

    modport master (
        output lft_smpl, rght_smpl, wrt_smpl,
        input  lft_out, rght_out, sequencing
    );

    modport slave (
        input  lft_smpl, rght_smpl, wrt_smpl,
        output lft_out, rght_out, sequencing
    );

endinterface

// File: rtl/lp_smpl_queue_stereo_dp_ram.sv
// Stereo sample store: DEPTH x 32 bits, one synchronous write port and one
// synchronous read port. Only the read-data register is reset; the array is not.
module stereo_dp_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:DEPTH-1];

    // Array write port, no reset on the storage itself
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; holds its value when no read is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/lp_smpl_queue.sv
// Circular stereo sample buffer that, once TAPS samples are held, replays the
// newest TAPS samples oldest-first to the downstream LP FIR after every write.
module lp_smpl_queue
    import eq_pkg::*;
#(
    parameter int unsigned TAPS  = DEF_TAPS,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input logic            clk,
    input logic            rst_n,
    lp_smpl_queue_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TAPS + 1);

    logic [AW-1:0] r_new_ptr;
    logic [AW-1:0] r_old_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_fill;
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    seq_state_t    r_state;
    seq_state_t    w_state_nxt;

    logic [AW-1:0] w_old_nxt;
    logic [AW-1:0] w_rd_addr;
    logic          w_full;
    logic          w_req;
    logic          w_start;
    logic          w_seq_last;
    logic          w_rd_en;
    logic [31:0]   w_rdata;

    assign w_full     = (r_fill == CW'(TAPS));
    // A write requests a readout when it leaves the window full
    assign w_req      = bus.wrt_smpl && (w_full || (r_fill == CW'(TAPS - 1)));
    assign w_old_nxt  = (bus.wrt_smpl && w_full) ? r_old_ptr + AW'(1) : r_old_ptr;
    assign w_seq_last = (r_cnt == CW'(TAPS));
    assign w_start    = (r_state == IDLE) && (w_req || r_pending);

    // Write/oldest pointers and saturating fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_ptr <= '0;
            r_old_ptr <= '0;
            r_fill    <= '0;
        end else begin
            r_old_ptr <= w_old_nxt;
            if (bus.wrt_smpl) begin
                r_new_ptr <= r_new_ptr + AW'(1);
                if (!w_full) begin
                    r_fill <= r_fill + CW'(1);
                end
            end
        end
    end

    // Readout bookkeeping: window base, cycle counter, single pending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (w_start) begin
            r_rd_ptr  <= w_old_nxt;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (r_state == SEQ) begin
            if (!w_seq_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start on request or leftover pending, end after TAPS+1 cycles
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)    w_state_nxt = SEQ;
            SEQ:     if (w_seq_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: window flag and read address for SEQ cycles 0..TAPS-1
    always_comb begin
        bus.sequencing = (r_state == SEQ);
        w_rd_en        = (r_state == SEQ) && !w_seq_last;
        w_rd_addr      = r_rd_ptr + AW'(r_cnt);
    end

    stereo_dp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (bus.wrt_smpl),
        .i_waddr (r_new_ptr),
        .i_wdata ({bus.lft_smpl, bus.rght_smpl}),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    assign bus.lft_out  = w_rdata[31:16];
    assign bus.rght_out = w_rdata[15:0];

endmodule

// File: tb/tb_lp_smpl_queue.sv
// Directed bench for lp_smpl_queue (TAPS=1021, DEPTH=1024). Sample n is
// written as n / -n, so the window after writing value v spans v-1020 .. v.
module tb_lp_smpl_queue;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] cap_l [0:2047];
    logic [15:0] cap_r [0:2047];

    lp_smpl_queue_if bus();

    lp_smpl_queue #(
        .TAPS  (1021),
        .DEPTH (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

    // One write strobe; returns at the negedge after the capturing edge
    task automatic wr(input int v);
        bus.lft_smpl  = 16'(v);
        bus.rght_smpl = 16'(-v);
        bus.wrt_smpl  = 1'b1;
        @(negedge clk);
        bus.wrt_smpl  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.wrt_smpl = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for sequencing, then records outputs of each SEQ cycle
    task automatic grab_window(input int budget, output int gap, output int len);
        gap = 0;
        while (gap < budget && bus.sequencing !== 1'b1) begin
            @(negedge clk);
            gap++;
        end
        len = 0;
        while (bus.sequencing === 1'b1 && len < 2048) begin
            cap_l[len] = bus.lft_out;
            cap_r[len] = bus.rght_out;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.wrt_smpl  = 1'b0;
        bus.lft_smpl  = '0;
        bus.rght_smpl = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.sequencing !== 1'b0) begin
            bad++; $display("FAIL rst_seq: got %b want 0", bus.sequencing);
        end
        total++;
        if (bus.lft_out !== 16'h0000 || bus.rght_out !== 16'h0000) begin
            bad++; $display("FAIL rst_out: got %h/%h want 0000/0000", bus.lft_out, bus.rght_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.sequencing !== 1'b0 || bus.lft_out !== 16'h0000) begin
            bad++; $display("FAIL post_rst: got seq=%b lft=%h want 0/0000", bus.sequencing, bus.lft_out);
        end
    endtask

    task automatic test_threshold();
        int seen = 0;
        int gap, len;
        for (int n = 0; n < 1020; n++) begin
            wr(n);
            if (bus.sequencing === 1'b1) seen++;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.sequencing === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL thr_quiet: got %0d sequencing cycles want 0", seen);
        end
        wr(32'h1234);
        total++;
        if (bus.sequencing !== 1'b1) begin
            bad++; $display("FAIL thr_rise: got %b want 1", bus.sequencing);
        end
        grab_window(10, gap, len);
        total++;
        if (len != 1022) begin
            bad++; $display("FAIL thr_len: got %0d want 1022", len);
        end
        total++;
        if (cap_l[1] !== 16'd0 || cap_l[1020] !== 16'd1019) begin
            bad++; $display("FAIL thr_head: got %0d,%0d want 0,1019", cap_l[1], cap_l[1020]);
        end
        total++;
        if (cap_l[1021] !== 16'h1234 || cap_r[1021] !== 16'hEDCC) begin
            bad++; $display("FAIL thr_last: got %h/%h want 1234/edcc", cap_l[1021], cap_r[1021]);
        end
    endtask

    task automatic test_ramp();
        int gap, len, nerr, fb;
        do_reset();
        for (int n = 0; n <= 1020; n++) wr(n);
        grab_window(10, gap, len);
        total++;
        if (len != 1022) begin
            bad++; $display("FAIL ramp_len: got %0d want 1022", len);
        end
        nerr = 0; fb = 0;
        for (int k = 1; k <= 1021; k++) begin
            if (cap_l[k] !== 16'(k - 1) || cap_r[k] !== 16'(1 - k)) begin
                if (nerr == 0) fb = k;
                nerr++;
            end
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL ramp_data: %0d bad, k=%0d got %0d/%0d want %0d/%0d", nerr, fb,
                            $signed(cap_l[fb]), $signed(cap_r[fb]), fb - 1, 1 - fb);
        end
        repeat (5) @(negedge clk);
        total++;
        if (bus.lft_out !== 16'd1020 || bus.rght_out !== 16'(-1020) || bus.sequencing !== 1'b0) begin
            bad++; $display("FAIL idle_hold: got %0d/%0d seq=%b want 1020/-1020 seq=0",
                            bus.lft_out, bus.rght_out, bus.sequencing);
        end
    endtask

    // Single writes with a full window each; v=1021 is the first slide,
    // later ones carry the pointers and read addresses across the wrap
    task automatic test_wrap();
        int gap, len, nerr, fb, first;
        for (int v = 1021; v <= 1026; v++) begin
            wr(v);
            grab_window(10, gap, len);
            first = v - 1020;
            total++;
            if (len != 1022 || gap != 0) begin
                bad++; $display("FAIL wrap_len v=%0d: got len=%0d gap=%0d want 1022/0", v, len, gap);
            end
            nerr = 0; fb = 0;
            for (int k = 1; k <= 1021; k++) begin
                if (cap_l[k] !== 16'(first + k - 1) || cap_r[k] !== 16'(-(first + k - 1))) begin
                    if (nerr == 0) fb = k;
                    nerr++;
                end
            end
            total++;
            if (nerr != 0) begin
                bad++; $display("FAIL wrap_data v=%0d: %0d bad, k=%0d got %0d want %0d", v, nerr, fb,
                                $signed(cap_l[fb]), first + fb - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int gap, len, nerr, fb, seen;
        wr(1027);
        fork
            grab_window(10, gap, len);
            begin
                repeat (100) @(negedge clk);
                wr(1028);
                repeat (100) @(negedge clk);
                wr(1029);
            end
        join
        total++;
        if (len != 1022) begin
            bad++; $display("FAIL pend_len1: got %0d want 1022", len);
        end
        total++;
        if (cap_l[1] !== 16'd7 || cap_l[1021] !== 16'd1027) begin
            bad++; $display("FAIL pend_data1: got %0d..%0d want 7..1027", cap_l[1], cap_l[1021]);
        end
        grab_window(10, gap, len);
        total++;
        if (gap != 1) begin
            bad++; $display("FAIL pend_gap: got %0d idle cycles want 1", gap);
        end
        total++;
        if (len != 1022) begin
            bad++; $display("FAIL pend_len2: got %0d want 1022", len);
        end
        nerr = 0; fb = 0;
        for (int k = 1; k <= 1021; k++) begin
            if (cap_l[k] !== 16'(k + 8) || cap_r[k] !== 16'(-(k + 8))) begin
                if (nerr == 0) fb = k;
                nerr++;
            end
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL pend_data2: %0d bad, k=%0d got %0d want %0d", nerr, fb,
                            $signed(cap_l[fb]), fb + 8);
        end
        seen = 0;
        repeat (1100) begin
            @(negedge clk);
            if (bus.sequencing === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL pend_once: got %0d extra sequencing cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen, gap, len, nerr, fb;
        wr(1030);
        repeat (500) @(negedge clk);
        total++;
        if (bus.sequencing !== 1'b1 || bus.lft_out !== 16'd509) begin
            bad++; $display("FAIL mid_pre: got seq=%b lft=%0d want 1/509", bus.sequencing, bus.lft_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.sequencing !== 1'b0 || bus.lft_out !== 16'h0000 || bus.rght_out !== 16'h0000) begin
            bad++; $display("FAIL mid_rst: got seq=%b out=%h/%h want 0/0000/0000",
                            bus.sequencing, bus.lft_out, bus.rght_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        seen = 0;
        for (int n = 0; n < 1020; n++) begin
            wr(n);
            if (bus.sequencing === 1'b1) seen++;
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.sequencing === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mid_quiet: got %0d sequencing cycles want 0", seen);
        end
        wr(1020);
        grab_window(10, gap, len);
        total++;
        if (len != 1022 || gap != 0) begin
            bad++; $display("FAIL mid_refill_len: got len=%0d gap=%0d want 1022/0", len, gap);
        end
        nerr = 0; fb = 0;
        for (int k = 1; k <= 1021; k++) begin
            if (cap_l[k] !== 16'(k - 1) || cap_r[k] !== 16'(1 - k)) begin
                if (nerr == 0) fb = k;
                nerr++;
            end
        end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL mid_refill_data: %0d bad, k=%0d got %0d want %0d", nerr, fb,
                            $signed(cap_l[fb]), fb - 1);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_ramp();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
